// File: rtl/fifo2mac_pkg.sv
// fifo2mac shared definitions: state encodings (also driven onto the
// debug LED bus) and default sizing for the TX FIFO to MAC bridge.
package fifo2mac_pkg;

    localparam int LEN_WIDTH_DEF = 12;
    localparam int MAX_LEN_DEF   = 1472;
    localparam int TIMEOUT_DEF   = 1000000;

    // Encodings are visible on the so[] debug output, keep them stable.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_START = 3'd2,
        ST_SEND  = 3'd3,
        ST_FIN   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Widen a state to the 4-bit LED bus.
    function automatic logic [3:0] so_code(input state_t s);
        return {1'b0, s};
    endfunction

endpackage

// File: rtl/fifo2mac_tx_watchdog.sv
// Cycle counter for the fifo2mac watchdog. Counts while en is high,
// reloads to zero on clr (or when disabled) and flags expiry on the
// LIMIT-th counted cycle. Only used when FIFO2MAC_TIMEOUT_EN is defined.
module fifo2mac_tx_watchdog #(
    parameter int LIMIT = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    // Saturating count of idle cycles; any progress reloads it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || !en) begin
            cnt <= '0;
        end else if (cnt != CW'(LIMIT)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = en && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/fifo2mac.sv
// fifo2mac: waits until the TX FIFO holds a whole payload, starts the MAC
// UDP transmitter and streams exactly tx_len bytes into its payload port.
// Optional watchdog on the active states: define FIFO2MAC_TIMEOUT_EN.
module fifo2mac
    import fifo2mac_pkg::*;
#(
    parameter int LEN_WIDTH      = LEN_WIDTH_DEF,
    parameter int MAX_LEN        = MAX_LEN_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fs,
    output logic                 fd,
    output logic                 err,
    input  logic [LEN_WIDTH-1:0] tx_len,
    input  logic [7:0]           fifo_rxd,
    output logic                 fifo_rxen,
    input  logic [LEN_WIDTH-1:0] fifo_count,
    output logic                 fs_udp_tx,
    input  logic                 fd_udp_tx,
    output logic [LEN_WIDTH-1:0] udp_tx_len,
    input  logic                 flag_udp_tx_req,
    output logic                 flag_udp_tx_prep,
    output logic                 udp_txen,
    output logic [7:0]           udp_txd,
    output logic [3:0]           so
);

    localparam logic [LEN_WIDTH-1:0] MAX_LEN_W = LEN_WIDTH'(MAX_LEN);
    localparam logic [LEN_WIDTH-1:0] ONE_W     = LEN_WIDTH'(1);

    state_t               state, state_nxt;
    logic [LEN_WIDTH-1:0] len_r;
    logic [LEN_WIDTH-1:0] rem;
    logic                 err_r;
    logic                 err_set;
    logic                 active;
    logic                 pop;
    logic                 wd_expired;

    assign active = (state == ST_WAIT) || (state == ST_START) ||
                    (state == ST_SEND) || (state == ST_FIN);

    // A pop needs a MAC request, bytes still owed and a non-empty FIFO.
    // An early MAC end or watchdog expiry in the same cycle wins over it so
    // unsent bytes stay in the FIFO.
    assign pop = flag_udp_tx_req && (rem != '0) && (fifo_count != '0) && !wd_expired &&
                 ((state == ST_START) || ((state == ST_SEND) && !fd_udp_tx));

`ifdef FIFO2MAC_TIMEOUT_EN
    fifo2mac_tx_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wd (
        .clk     (clk),
        .rst     (rst),
        .en      (active),
        .clr     (pop || (state_nxt != state)),
        .expired (wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    // Next-state and error-set decode.
    always_comb begin
        state_nxt = state;
        err_set   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fs) begin
                    if (tx_len == '0 || tx_len > MAX_LEN_W) state_nxt = ST_DONE;
                    else                                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT:  if (fifo_count >= len_r) state_nxt = ST_START;
            ST_START: if (flag_udp_tx_req) state_nxt = ST_SEND;
            ST_SEND: begin
                if (fd_udp_tx) begin
                    state_nxt = ST_DONE;
                    err_set   = (rem != '0);
                end else if (rem == '0 || (pop && rem == ONE_W)) begin
                    state_nxt = ST_FIN;
                end
            end
            ST_FIN:  if (fd_udp_tx) state_nxt = ST_DONE;
            ST_DONE: if (!fs) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (active && wd_expired) begin
            state_nxt = ST_DONE;
            err_set   = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Length latch, byte countdown, status and the registered payload port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_r    <= '0;
            rem      <= '0;
            err_r    <= 1'b0;
            udp_txen <= 1'b0;
            udp_txd  <= '0;
        end else begin
            udp_txen <= pop;
            if (pop) begin
                udp_txd <= fifo_rxd;
                rem     <= rem - ONE_W;
            end
            if (state == ST_IDLE && fs) begin
                len_r <= tx_len;
                rem   <= tx_len;
                err_r <= (tx_len > MAX_LEN_W);
            end else if (err_set) begin
                err_r <= 1'b1;
            end
        end
    end

    assign fd               = (state == ST_DONE);
    assign err              = err_r;
    assign fifo_rxen        = pop;
    assign fs_udp_tx        = (state == ST_START) || (state == ST_SEND) || (state == ST_FIN);
    assign udp_tx_len       = fs_udp_tx ? len_r : '0;
    assign flag_udp_tx_prep = (state == ST_START) || (state == ST_SEND);
    assign so               = so_code(state);

endmodule

// File: tb/tb_fifo2mac.sv
// Bench for fifo2mac: FWFT FIFO model plus a MAC stand-in, byte scoreboard
// filled when the FIFO is loaded and drained as udp_txen bytes appear.
module tb_fifo2mac;

    localparam int LW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          fs = 1'b0;
    logic          fd, err;
    logic [LW-1:0] tx_len = '0;
    logic [7:0]    fifo_rxd = '0;
    logic          fifo_rxen;
    logic [LW-1:0] fifo_count = '0;
    logic          fs_udp_tx;
    logic          fd_udp_tx = 1'b0;
    logic [LW-1:0] udp_tx_len;
    logic          flag_udp_tx_req = 1'b0;
    logic          flag_udp_tx_prep;
    logic          udp_txen;
    logic [7:0]    udp_txd;
    logic [3:0]    so;

    fifo2mac #(.LEN_WIDTH(LW), .MAX_LEN(1472), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst), .fs(fs), .fd(fd), .err(err), .tx_len(tx_len),
        .fifo_rxd(fifo_rxd), .fifo_rxen(fifo_rxen), .fifo_count(fifo_count),
        .fs_udp_tx(fs_udp_tx), .fd_udp_tx(fd_udp_tx), .udp_tx_len(udp_tx_len),
        .flag_udp_tx_req(flag_udp_tx_req), .flag_udp_tx_prep(flag_udp_tx_prep),
        .udp_txen(udp_txen), .udp_txd(udp_txd), .so(so)
    );

    always #5 clk = ~clk;

    logic [7:0] fq[$];      // FIFO contents
    logic [7:0] expq[$];    // bytes the MAC must receive, in order
    bit         txen_log[$];
    int         n_vec = 0, n_bad = 0;
    int         pops = 0, txcnt = 0;
    bit         saw_fs = 1'b0;
    logic       pop_s;

    typedef struct {
        int len;
        int fill;
        int exp_err;
        bit mac;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic upd();
        fifo_count = LW'(fq.size());
        fifo_rxd   = (fq.size() != 0) ? fq[0] : 8'h00;
    endtask

    task automatic load(input int n, input int base, input int nexp);
        for (int i = 0; i < n; i++) begin
            fq.push_back(8'((base + i) & 255));
            if (i < nexp) expq.push_back(8'((base + i) & 255));
        end
        upd();
    endtask

    // One clock: observe on the falling edge, apply FIFO pops just after
    // the rising edge so the DUT captured the pre-pop head byte.
    task automatic cyc();
        logic [7:0] e;
        @(negedge clk);
        pop_s = fifo_rxen;
        if (fs_udp_tx) saw_fs = 1'b1;
        if (fifo_rxen) begin
            pops++;
            chk("fifo_nonempty_at_pop", int'(fq.size() != 0), 1);
        end
        txen_log.push_back(udp_txen);
        if (udp_txen) begin
            txcnt++;
            chk("byte_expected", int'(expq.size() != 0), 1);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                chk("udp_txd", udp_txd, e);
            end
        end
        @(posedge clk);
        #1;
        if (pop_s && fq.size() != 0) void'(fq.pop_front());
        upd();
    endtask

    task automatic wait_start(input string nm);
        for (int i = 0; i < 50 && so != 4'd2; i++) cyc();
        chk({nm, "_start"}, so, 2);
    endtask

    // MAC side: request every cycle until FIN, then finish the frame.
    task automatic mac_run(input string nm, input int len);
        wait_start(nm);
        chk({nm, "_udp_tx_len"}, udp_tx_len, len);
        chk({nm, "_prep"}, flag_udp_tx_prep, 1);
        chk({nm, "_fs_udp_tx"}, fs_udp_tx, 1);
        txen_log.delete();
        flag_udp_tx_req = 1'b1;
        for (int i = 0; i < len + 5 && so != 4'd4; i++) cyc();
        chk({nm, "_fin"}, so, 4);
        cyc();
        cyc();
        flag_udp_tx_req = 1'b0;
        chk({nm, "_txen_at_req"}, int'(txen_log[0]), 0);
        chk({nm, "_txen_after_req"}, int'(txen_log[1]), 1);
        chk({nm, "_fs_held_fin"}, fs_udp_tx, 1);
        fd_udp_tx = 1'b1;
        cyc();
        fd_udp_tx = 1'b0;
        chk({nm, "_fs_drop"}, fs_udp_tx, 0);
    endtask

    task automatic fin(input string nm, input int exp_err, input int nbytes);
        for (int i = 0; i < 20 && !fd; i++) cyc();
        chk({nm, "_fd"}, fd, 1);
        chk({nm, "_err"}, err, exp_err);
        chk({nm, "_bytes"}, txcnt, nbytes);
        chk({nm, "_pops"}, pops, nbytes);
        chk({nm, "_scoreboard_left"}, expq.size(), 0);
        cyc();
        chk({nm, "_done_hold"}, so, 5);
        fs = 1'b0;
        cyc();
        chk({nm, "_idle"}, so, 0);
        chk({nm, "_fd_clear"}, fd, 0);
    endtask

    initial begin
        bit exp_pause[10] = '{0, 1, 0, 0, 1, 1, 0, 1, 0, 0};
        int req_pat[7] = '{1, 0, 0, 1, 1, 0, 1};

        vecs[0] = '{len: 16,   fill: 16,   exp_err: 0, mac: 1'b1};
        vecs[1] = '{len: 0,    fill: 0,    exp_err: 0, mac: 1'b0};
        vecs[2] = '{len: 1473, fill: 0,    exp_err: 1, mac: 1'b0};
        vecs[3] = '{len: 1,    fill: 1,    exp_err: 0, mac: 1'b1};
        vecs[4] = '{len: 1472, fill: 1472, exp_err: 0, mac: 1'b1};

        // Reset state
        upd();
        cyc();
        cyc();
        chk("rst_so", so, 0);
        chk("rst_fd", fd, 0);
        chk("rst_err", err, 0);
        chk("rst_fs_udp_tx", fs_udp_tx, 0);
        chk("rst_udp_tx_len", udp_tx_len, 0);
        chk("rst_txen", udp_txen, 0);
        rst = 1'b1;
        cyc();

        // Table of whole transfers
        for (int v = 0; v < 5; v++) begin
            pops   = 0;
            txcnt  = 0;
            saw_fs = 1'b0;
            load(vecs[v].fill, (v == 0) ? 1 : 8'h40 + v * 17, vecs[v].mac ? vecs[v].len : 0);
            tx_len = LW'(vecs[v].len);
            fs     = 1'b1;
            cyc();
            if (vecs[v].mac) mac_run($sformatf("vec%0d", v), vecs[v].len);
            else begin
                cyc();
                chk($sformatf("vec%0d_no_mac_start", v), int'(saw_fs), 0);
            end
            fin($sformatf("vec%0d", v), vecs[v].exp_err, vecs[v].mac ? vecs[v].len : 0);
            chk($sformatf("vec%0d_fifo_left", v), fifo_count, 0);
        end

        // Late data: partial payload must not start the MAC
        pops = 0; txcnt = 0;
        load(3, 8'h10, 3);
        tx_len = 8; fs = 1'b1;
        repeat (6) cyc();
        chk("late_wait", so, 1);
        chk("late_no_fs", fs_udp_tx, 0);
        load(5, 8'h13, 5);
        cyc();
        chk("late_start", so, 2);
        mac_run("late", 8);
        fin("late", 0, 8);

        // Paused request pattern, plus requests after the last byte
        pops = 0; txcnt = 0;
        load(6, 8'hA0, 4);
        tx_len = 4; fs = 1'b1;
        cyc();
        wait_start("pause");
        txen_log.delete();
        for (int i = 0; i < 7; i++) begin
            flag_udp_tx_req = req_pat[i][0];
            cyc();
        end
        flag_udp_tx_req = 1'b1;
        cyc();
        cyc();
        flag_udp_tx_req = 1'b0;
        cyc();
        for (int i = 0; i < 10; i++)
            chk($sformatf("pause_txen%0d", i), int'(txen_log[i]), int'(exp_pause[i]));
        chk("pause_pops", pops, 4);
        chk("pause_fifo_left", fifo_count, 2);
        fd_udp_tx = 1'b1;
        cyc();
        fd_udp_tx = 1'b0;
        fin("pause", 0, 4);
        fq.delete(); upd();

        // Early end from the MAC after two bytes
        pops = 0; txcnt = 0;
        load(6, 8'h30, 2);
        tx_len = 6; fs = 1'b1;
        cyc();
        wait_start("abort");
        flag_udp_tx_req = 1'b1;
        cyc();
        cyc();
        flag_udp_tx_req = 1'b0;
        fd_udp_tx = 1'b1;
        cyc();
        fd_udp_tx = 1'b0;
        chk("abort_fifo_left", fifo_count, 4);
        fin("abort", 1, 2);
        fq.delete(); upd();

        // Asynchronous reset in the middle of SEND
        pops = 0; txcnt = 0;
        load(4, 8'h50, 0);
        tx_len = 4; fs = 1'b1;
        cyc();
        wait_start("rst");
        flag_udp_tx_req = 1'b1;
        cyc();
        chk("rst_in_send", so, 3);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_so", so, 0);
        chk("arst_fd", fd, 0);
        chk("arst_err", err, 0);
        chk("arst_rxen", fifo_rxen, 0);
        chk("arst_fs_udp_tx", fs_udp_tx, 0);
        chk("arst_udp_tx_len", udp_tx_len, 0);
        chk("arst_prep", flag_udp_tx_prep, 0);
        chk("arst_txen", udp_txen, 0);
        chk("arst_txd", udp_txd, 0);
        flag_udp_tx_req = 1'b0;
        fs = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        chk("post_rst_so", so, 0);
        chk("post_rst_fd", fd, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: run did not end, want end before 2000000");
        $fatal(1);
    end

endmodule
